// File: rtl/obstacle_spawner.sv
// Obstacle spawn scheduler: turns the free-running random word into timed
// spawn requests (gap countdown in frame ticks, then type/height) over valid/ready.
module obstacle_spawner #(
  parameter int unsigned MIN_GAP    = 40,
  parameter int unsigned GAP_FLOOR  = 16,
  parameter int unsigned BIRD_SPEED = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] rnd,
  input  logic        tick,
  input  logic        run,
  input  logic [3:0]  speed,
  input  logic        spawn_ready,
  output logic        spawn_valid,
  output logic [1:0]  spawn_type,
  output logic [1:0]  spawn_height,
  output logic [15:0] spawn_count
);

  localparam int unsigned GAP_W = 8;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, OFFER} state_t;

  state_t             state, state_next;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;
  logic               valid_next;
  logic [1:0]         type_next, height_next;
  logic [CNT_W-1:0]   count_next;

  logic signed [9:0]  g_c;
  logic [GAP_W-1:0]   gap_c;
  logic [1:0]         type_c, height_c;
  logic               bird_ok_c;
  logic               handshake_c;
  logic               unused_rnd_c;

  assign unused_rnd_c = ^{rnd[29:12], rnd[7:6]};
  assign handshake_c  = spawn_valid && spawn_ready;
  assign bird_ok_c    = ({1'b0, speed} >= 5'(BIRD_SPEED));

  // Speed-compensated gap, evaluated signed so a large speed cannot wrap past the floor.
  always_comb begin
    g_c   = $signed(10'(MIN_GAP)) + $signed({4'b0, rnd[5:0]}) - $signed({5'b0, speed, 1'b0});
    gap_c = (g_c < $signed(10'(GAP_FLOOR))) ? GAP_W'(GAP_FLOOR) : g_c[GAP_W-1:0];
  end

  // Obstacle type and bird altitude; the 2'b11 altitude code folds onto the middle lane.
  always_comb begin
    type_c   = 2'd0;
    height_c = 2'd0;
    if (rnd[9]) begin
      if (rnd[8] && bird_ok_c) begin
        type_c   = 2'd2;
        height_c = (rnd[11:10] == 2'b11) ? 2'd1 : rnd[11:10];
      end else begin
        type_c = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      spawn_valid  <= 1'b0;
      spawn_type   <= 2'd0;
      spawn_height <= 2'd0;
      spawn_count  <= '0;
    end else begin
      state        <= state_next;
      gap_cnt      <= gap_cnt_next;
      spawn_valid  <= valid_next;
      spawn_type   <= type_next;
      spawn_height <= height_next;
      spawn_count  <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!run) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = WAIT;
        WAIT:    if (tick && gap_cnt == GAP_W'(1)) state_next = OFFER;
        OFFER:   if (handshake_c) state_next = WAIT;
        default: state_next = IDLE;
      endcase
    end
  end

  // A handshake coinciding with run falling still counts.
  always_comb begin
    gap_cnt_next = gap_cnt;
    valid_next   = spawn_valid;
    type_next    = spawn_type;
    height_next  = spawn_height;
    count_next   = spawn_count + CNT_W'(handshake_c);
    if (!run) begin
      gap_cnt_next = '0;
      valid_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gap_cnt_next = gap_c;
          valid_next   = 1'b0;
        end
        WAIT: begin
          if (tick) begin
            gap_cnt_next = gap_cnt - GAP_W'(1);
            if (gap_cnt == GAP_W'(1)) begin
              valid_next  = 1'b1;
              type_next   = type_c;
              height_next = height_c;
            end
          end
        end
        OFFER: begin
          if (handshake_c) begin
            gap_cnt_next = gap_c;
            valid_next   = 1'b0;
          end
        end
        default: begin
          gap_cnt_next = '0;
          valid_next   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: gap timing, floor, decode, back-pressure,
// run drop and asynchronous reset, with a second instance for the signed floor case.
module tb_obstacle_spawner;

  logic        clk = 1'b0;
  logic        rst_n, tick, run, run2, spawn_ready, spawn_ready2;
  logic [29:0] rnd;
  logic [3:0]  speed;
  logic        spawn_valid, spawn_valid2;
  logic [1:0]  spawn_type, spawn_type2, spawn_height, spawn_height2;
  logic [15:0] spawn_count, spawn_count2;

  int errors = 0;
  int checks = 0;
  logic stable;

  always #5 clk = ~clk;

  obstacle_spawner dut (
    .clk(clk), .rst_n(rst_n), .rnd(rnd), .tick(tick), .run(run), .speed(speed),
    .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_type(spawn_type),
    .spawn_height(spawn_height), .spawn_count(spawn_count)
  );

  obstacle_spawner #(.MIN_GAP(16), .GAP_FLOOR(1), .BIRD_SPEED(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .rnd(rnd), .tick(tick), .run(run2), .speed(speed),
    .spawn_ready(spawn_ready2), .spawn_valid(spawn_valid2), .spawn_type(spawn_type2),
    .spawn_height(spawn_height2), .spawn_count(spawn_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; rnd = 30'($urandom); step();
    tick = 1'b0; rnd = 30'($urandom); step();
  endtask

  // n ticks from a freshly loaded counter; valid must rise only after the n-th.
  task automatic run_gap(input int n, input logic [29:0] fin, input string tag);
    for (int i = 0; i < n - 1; i++) pulse_tick();
    check({tag, " valid before last tick"}, 32'(spawn_valid), 32'd0);
    tick = 1'b1; rnd = fin; step();
    tick = 1'b0; rnd = 30'($urandom);
    check({tag, " valid one clk after last tick"}, 32'(spawn_valid), 32'd1);
  endtask

  task automatic hs(input logic [29:0] r, input logic [3:0] s);
    spawn_ready = 1'b1; rnd = r; speed = s; step();
    spawn_ready = 1'b0; rnd = 30'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; run2 = 1'b0; tick = 1'b0;
    spawn_ready = 1'b0; spawn_ready2 = 1'b0; speed = 4'd0; rnd = '0;
    step(); step();
    check("reset valid", 32'(spawn_valid), 32'd0);
    check("reset type", 32'(spawn_type), 32'd0);
    check("reset height", 32'(spawn_height), 32'd0);
    check("reset count", 32'(spawn_count), 32'd0);
    rst_n = 1'b1; step(); step();
    check("idle without run", 32'(spawn_valid), 32'd0);

    // Basic: 40 + 5 - 0 = 45 ticks; ready held high while idle/waiting is ignored.
    spawn_ready = 1'b1; speed = 4'd0; rnd = 30'h005; run = 1'b1; step();
    run_gap(45, 30'h100, "basic");
    check("basic type small cactus", 32'(spawn_type), 32'd0);
    check("basic height", 32'(spawn_height), 32'd0);
    check("basic count before accept", 32'(spawn_count), 32'd0);
    hs(30'h000, 4'd15);
    check("basic count after accept", 32'(spawn_count), 32'd1);
    check("basic valid after accept", 32'(spawn_valid), 32'd0);

    // Floor 40 - 30 = 10 -> 16; speed change mid-wait must not alter the count.
    speed = 4'd2;
    run_gap(16, 30'hB00, "floor");
    check("decode 1011 speed2 type", 32'(spawn_type), 32'd1);
    check("decode 1011 speed2 height", 32'(spawn_height), 32'd0);
    hs(30'h000, 4'd15);
    speed = 4'd4;
    run_gap(16, 30'hB00, "bird h2");
    check("decode 1011 speed4 type", 32'(spawn_type), 32'd2);
    check("decode 1011 speed4 height", 32'(spawn_height), 32'd2);
    check("count after two accepts", 32'(spawn_count), 32'd2);
    hs(30'h000, 4'd15);
    speed = 4'd4;
    run_gap(16, 30'hF00, "bird h1");
    check("decode 1111 speed4 type", 32'(spawn_type), 32'd2);
    check("decode 1111 speed4 height", 32'(spawn_height), 32'd1);

    // Back-pressure: 100 ticks with ready low.
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick = 1'b1; rnd = 30'($urandom); step();
      stable &= (spawn_valid === 1'b1) && (spawn_type === 2'd2) && (spawn_height === 2'd1);
      tick = 1'b0; rnd = 30'($urandom); step();
      stable &= (spawn_valid === 1'b1) && (spawn_type === 2'd2) && (spawn_height === 2'd1);
    end
    check("backpressure offer stable", 32'(stable), 32'd1);
    check("backpressure count held", 32'(spawn_count), 32'd3);
    hs(30'h007, 4'd0);
    check("backpressure single accept", 32'(spawn_count), 32'd4);
    check("backpressure valid drops", 32'(spawn_valid), 32'd0);
    speed = 4'd0;
    run_gap(47, 30'h200, "gap from accept rnd");
    check("decode 10 type", 32'(spawn_type), 32'd1);

    // run drop while waiting.
    hs(30'h000, 4'd0);
    pulse_tick(); pulse_tick(); pulse_tick();
    run = 1'b0; step();
    check("run drop wait valid", 32'(spawn_valid), 32'd0);
    check("run drop wait count", 32'(spawn_count), 32'd5);
    pulse_tick(); pulse_tick();
    check("idle ignores ticks", 32'(spawn_valid), 32'd0);
    run = 1'b1; rnd = 30'h003; speed = 4'd10; step();
    speed = 4'd0;
    run_gap(23, 30'h300, "restart");
    check("decode 11 slow type", 32'(spawn_type), 32'd1);
    check("count survives restart", 32'(spawn_count), 32'd5);

    // run drop in the same cycle as a handshake.
    spawn_ready = 1'b1; run = 1'b0; rnd = 30'h03F; speed = 4'd0; step();
    spawn_ready = 1'b0;
    check("run drop hs valid", 32'(spawn_valid), 32'd0);
    check("run drop hs count", 32'(spawn_count), 32'd6);
    pulse_tick(); pulse_tick();
    run = 1'b1; rnd = 30'h000; speed = 4'd15; step();
    run_gap(16, 30'hB00, "restart after hs drop");
    check("count survives hs-drop restart", 32'(spawn_count), 32'd6);

    // Asynchronous reset in the middle of an offer.
    rst_n = 1'b0; #1;
    check("async reset valid", 32'(spawn_valid), 32'd0);
    check("async reset type", 32'(spawn_type), 32'd0);
    check("async reset height", 32'(spawn_height), 32'd0);
    check("async reset count", 32'(spawn_count), 32'd0);
    step();
    rst_n = 1'b1; rnd = 30'h000; speed = 4'd15; step();
    run_gap(16, 30'h100, "post reset");
    hs(30'h000, 4'd0);
    check("post reset count", 32'(spawn_count), 32'd1);

    // Second instance: 16 + 0 - 30 = -14 signed, floored to 1.
    run = 1'b0;
    run2 = 1'b1; speed = 4'd15; rnd = 30'h000; step();
    check("signed floor valid before tick", 32'(spawn_valid2), 32'd0);
    tick = 1'b1; rnd = 30'($urandom); step();
    tick = 1'b0;
    check("signed floor gap 1", 32'(spawn_valid2), 32'd1);
    spawn_ready2 = 1'b1; step();
    spawn_ready2 = 1'b0;
    check("signed floor count", 32'(spawn_count2), 32'd1);
    check("signed floor valid drops", 32'(spawn_valid2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
